// File: rtl/veggie_trajectory.sv
`default_nettype none
// ============================================================================
//  Module      : veggie_trajectory
//  Description : Per-frame physics for one veggie. Launches from the LFSR word,
//                flies under gravity with wall bounces, splits into two halves
//                on katana contact and respawns after both halves fall away.
//                Optional macro VEGGIE_SCORE_EN adds score_out / miss_out.
//  Revision    : 1.0 - initial release
// ============================================================================
module veggie_trajectory #(
    parameter int SCREEN_W       = 1024,
    parameter int SCREEN_H       = 768,
    parameter int VEG_W          = 128,
    parameter int VEG_H          = 128,
    parameter int GRAVITY        = 1,
    parameter int LAUNCH_VY      = 24,
    parameter int SPLIT_VX       = 3,
    parameter int RESPAWN_FRAMES = 30
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        frame_done_in,
    input  logic        split_in,
    input  logic [15:0] random_in,
    output logic [10:0] top_x_out,
    output logic [9:0]  top_y_out,
    output logic [10:0] bottom_x_out,
    output logic [9:0]  bottom_y_out,
    output logic        split_out,
`ifdef VEGGIE_SCORE_EN
    output logic        veggie_gone_out,
    output logic [7:0]  score_out,
    output logic [7:0]  miss_out
`else
    output logic        veggie_gone_out
`endif
);

    localparam logic [11:0] c_FLOOR     = 12'(SCREEN_H - VEG_H);
    localparam logic [11:0] c_XMAX      = 12'(SCREEN_W - VEG_W);
    localparam logic [11:0] c_X_HOME    = 12'(SCREEN_W / 2 - VEG_W / 2);
    localparam logic [11:0] c_LAUNCH_X  = 12'd128;
    localparam logic [7:0]  c_VY_MAX    = 8'd63;
    localparam logic [7:0]  c_SPLIT_DVY = 8'd2;
    localparam logic [7:0]  c_RESPAWN   = 8'(RESPAWN_FRAMES);

    typedef enum logic [1:0] {
        ST_RESPAWN = 2'd0,
        ST_FLYING  = 2'd1,
        ST_SPLIT   = 2'd2
    } state_t;

    // Position and velocity of one half; all fields are two's complement.
    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic [7:0]  vx;
        logic [7:0]  vy;
    } half_t;

    localparam half_t c_HALF_RST = '{x: c_X_HOME, y: c_FLOOR, vx: 8'd0, vy: 8'd0};

    // One frame of motion: x with wall bounce, y by vy, then gravity with clamp.
    function automatic half_t f_step(input half_t h);
        half_t              r;
        logic        [12:0] xs;
        logic        [8:0]  vys;
        r   = h;
        xs  = {h.x[11], h.x} + {{5{h.vx[7]}}, h.vx};
        if (xs[12]) begin
            r.x  = 12'd0;
            r.vx = 8'd0 - h.vx;
        end else if ($signed(xs) > $signed({1'b0, c_XMAX})) begin
            r.x  = c_XMAX;
            r.vx = 8'd0 - h.vx;
        end else begin
            r.x  = xs[11:0];
        end
        r.y = h.y + {{4{h.vy[7]}}, h.vy};
        vys = {h.vy[7], h.vy} + 9'(GRAVITY);
        if (!vys[8] && vys[7:0] > c_VY_MAX) begin
            r.vy = c_VY_MAX;
        end else begin
            r.vy = vys[7:0];
        end
        return r;
    endfunction

    // A half leaves the screen when it was moving down and its new y passes the floor.
    function automatic logic f_falls(input half_t cur, input half_t nxt);
        return ($signed(nxt.y) > $signed(c_FLOOR)) && ($signed(cur.vy) > 8'sd0);
    endfunction

    state_t      r_state, w_state_n;
    logic [7:0]  r_cnt, w_cnt_n;
    half_t       r_top, w_top_n, r_bot, w_bot_n;
    half_t       w_top_eff, w_bot_eff, w_top_mv, w_bot_mv;
    logic        r_pend, w_pend_n;
    logic        r_top_fz, w_top_fz_n, r_bot_fz, w_bot_fz_n;
    logic        w_split_now, w_top_falls, w_bot_falls;
    logic        w_unused;

    assign w_unused    = ^random_in[15:14];
    assign w_split_now = (r_state == ST_FLYING) && r_pend;

    // Velocities as seen by this tick, with the split kick applied when one is pending.
    always_comb begin
        w_top_eff = r_top;
        w_bot_eff = r_bot;
        if (w_split_now) begin
            w_top_eff.vx = r_top.vx - 8'(SPLIT_VX);
            w_bot_eff.vx = r_bot.vx + 8'(SPLIT_VX);
            w_bot_eff.vy = r_bot.vy + c_SPLIT_DVY;
        end
    end

    assign w_top_mv    = f_step(w_top_eff);
    assign w_bot_mv    = f_step(w_bot_eff);
    assign w_top_falls = f_falls(w_top_eff, w_top_mv);
    assign w_bot_falls = f_falls(w_bot_eff, w_bot_mv);

    // Next-state, counter, pending-split and per-half position decisions.
    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_top_n    = r_top;
        w_bot_n    = r_bot;
        w_pend_n   = r_pend;
        w_top_fz_n = r_top_fz;
        w_bot_fz_n = r_bot_fz;

        // A pulse is only remembered while flying; one arriving on a tick waits for the next.
        if (r_state == ST_FLYING && split_in) begin
            w_pend_n = 1'b1;
        end

        if (frame_done_in) begin
            case (r_state)
                ST_RESPAWN: begin
                    if (r_cnt != 8'd0) begin
                        w_cnt_n = r_cnt - 8'd1;
                    end else begin
                        w_top_n.x  = c_LAUNCH_X + {3'b000, random_in[8:0]};
                        w_top_n.y  = c_FLOOR;
                        w_top_n.vx = {{5{random_in[11]}}, random_in[11:9]};
                        w_top_n.vy = 8'd0 - (8'(LAUNCH_VY) + {6'b0, random_in[13:12]});
                        w_bot_n    = w_top_n;
                        w_top_fz_n = 1'b0;
                        w_bot_fz_n = 1'b0;
                        w_pend_n   = 1'b0;
                        w_state_n  = ST_FLYING;
                    end
                end
                ST_FLYING: begin
                    if (r_pend) begin
                        // Split takes priority over a simultaneous floor exit.
                        w_top_n    = w_top_falls ? w_top_eff : w_top_mv;
                        w_bot_n    = w_bot_falls ? w_bot_eff : w_bot_mv;
                        w_top_fz_n = w_top_falls;
                        w_bot_fz_n = w_bot_falls;
                        w_pend_n   = 1'b0;
                        w_state_n  = ST_SPLIT;
                    end else if (w_top_falls) begin
                        w_pend_n  = 1'b0;
                        w_cnt_n   = c_RESPAWN;
                        w_state_n = ST_RESPAWN;
                    end else begin
                        w_top_n = w_top_mv;
                        w_bot_n = w_bot_mv;
                    end
                end
                ST_SPLIT: begin
                    if (!r_top_fz) begin
                        if (w_top_falls) w_top_fz_n = 1'b1;
                        else             w_top_n    = w_top_mv;
                    end
                    if (!r_bot_fz) begin
                        if (w_bot_falls) w_bot_fz_n = 1'b1;
                        else             w_bot_n    = w_bot_mv;
                    end
                    if (w_top_fz_n && w_bot_fz_n) begin
                        w_cnt_n   = c_RESPAWN;
                        w_state_n = ST_RESPAWN;
                    end
                end
                default: begin
                    w_state_n = ST_RESPAWN;
                    w_cnt_n   = c_RESPAWN;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state  <= ST_RESPAWN;
            r_cnt    <= c_RESPAWN;
            r_top    <= c_HALF_RST;
            r_bot    <= c_HALF_RST;
            r_pend   <= 1'b0;
            r_top_fz <= 1'b0;
            r_bot_fz <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_top    <= w_top_n;
            r_bot    <= w_bot_n;
            r_pend   <= w_pend_n;
            r_top_fz <= w_top_fz_n;
            r_bot_fz <= w_bot_fz_n;
        end
    end

`ifdef VEGGIE_SCORE_EN
    logic [7:0] r_score, r_miss;

    // Saturating hit and miss counters, stepped on leaving FLYING.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_score <= 8'd0;
            r_miss  <= 8'd0;
        end else if (r_state == ST_FLYING) begin
            if (w_state_n == ST_SPLIT && r_score != 8'hFF)   r_score <= r_score + 8'd1;
            if (w_state_n == ST_RESPAWN && r_miss != 8'hFF)  r_miss  <= r_miss + 8'd1;
        end
    end

    assign score_out = r_score;
    assign miss_out  = r_miss;
`endif

    assign top_x_out       = r_top.x[10:0];
    assign top_y_out       = r_top.y[9:0];
    assign bottom_x_out    = r_bot.x[10:0];
    assign bottom_y_out    = r_bot.y[9:0];
    assign split_out       = (r_state == ST_SPLIT);
    assign veggie_gone_out = (r_state == ST_RESPAWN);

endmodule
`default_nettype wire

// File: tb/tb_veggie_trajectory.sv
`default_nettype none
// ============================================================================
//  Module      : tb_veggie_trajectory
//  Description : Table-driven self-checking bench for veggie_trajectory with a
//                scoreboard queue of expected outputs per frame tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_veggie_trajectory;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        frame_done_in = 1'b0;
    logic        split_in = 1'b0;
    logic [15:0] random_in = 16'h0000;
    logic [10:0] top_x_out, bottom_x_out;
    logic [9:0]  top_y_out, bottom_y_out;
    logic        split_out, veggie_gone_out;
`ifdef VEGGIE_SCORE_EN
    logic [7:0]  score_out, miss_out;
`endif

    veggie_trajectory dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .frame_done_in   (frame_done_in),
        .split_in        (split_in),
        .random_in       (random_in),
        .top_x_out       (top_x_out),
        .top_y_out       (top_y_out),
        .bottom_x_out    (bottom_x_out),
        .bottom_y_out    (bottom_y_out),
        .split_out       (split_out),
`ifdef VEGGIE_SCORE_EN
        .veggie_gone_out (veggie_gone_out),
        .score_out       (score_out),
        .miss_out        (miss_out)
`else
        .veggie_gone_out (veggie_gone_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int tx; int ty; int bx; int by;
        int sp; int gone; int score; int miss;
    } exp_t;

    typedef struct {
        logic [15:0] rnd;
        int          npulse;
        bit          sim;
        int          n;
        exp_t        e;
    } vec_t;

    vec_t vq[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic [15:0] rnd, input int npulse, input bit sim, input int n,
                       input int tx, input int ty, input int bx, input int by,
                       input int sp, input int gone, input int score, input int miss);
        vec_t v;
        v.rnd = rnd; v.npulse = npulse; v.sim = sim; v.n = n;
        v.e = '{tx, ty, bx, by, sp, gone, score, miss};
        vq.push_back(v);
    endtask

    task automatic compare_pop(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got nothing expected an entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".top_x"},    int'(top_x_out),       e.tx);
            chk({tag, ".top_y"},    int'(top_y_out),       e.ty);
            chk({tag, ".bottom_x"}, int'(bottom_x_out),    e.bx);
            chk({tag, ".bottom_y"}, int'(bottom_y_out),    e.by);
            chk({tag, ".split"},    int'(split_out),       e.sp);
            chk({tag, ".gone"},     int'(veggie_gone_out), e.gone);
`ifdef VEGGIE_SCORE_EN
            chk({tag, ".score"},    int'(score_out),       e.score);
            chk({tag, ".miss"},     int'(miss_out),        e.miss);
`endif
        end
    endtask

    // One frame tick; optionally a split pulse in the same cycle and an expected result.
    task automatic tick(input bit with_split, input bit expect_now, input exp_t e, input string tag);
        @(negedge clk_in);
        frame_done_in = 1'b1;
        split_in      = with_split;
        if (expect_now) sb.push_back(e);
        @(posedge clk_in);
        #1;
        frame_done_in = 1'b0;
        split_in      = 1'b0;
        if (expect_now) compare_pop(tag);
    endtask

    initial begin
        exp_t e;
        // rnd, pulses, same-cycle split, ticks | top x,y  bottom x,y  split gone score miss
        add(16'h0000, 0, 0, 30, 448, 640, 448, 640, 0, 1, 0, 0);
        add(16'h0000, 0, 0,  1, 128, 640, 128, 640, 0, 0, 0, 0);
        add(16'h0000, 0, 0,  1, 128, 616, 128, 616, 0, 0, 0, 0);
        add(16'h0000, 0, 0, 23, 128, 340, 128, 340, 0, 0, 0, 0);
        add(16'h0000, 0, 0, 25, 128, 640, 128, 640, 0, 0, 0, 0);
        add(16'h0000, 0, 0,  1, 128, 640, 128, 640, 0, 1, 0, 1);
        add(16'h0800, 0, 0, 31, 128, 640, 128, 640, 0, 0, 0, 1);
        add(16'h0800, 0, 0, 32,   0, 368,   0, 368, 0, 0, 0, 1);
        add(16'h0800, 0, 0,  1,   0, 376,   0, 376, 0, 0, 0, 1);
        add(16'h0800, 0, 0,  1,   4, 385,   4, 385, 0, 0, 0, 1);
        add(16'h0800, 0, 0, 15,  64, 640,  64, 640, 0, 0, 0, 1);
        add(16'h0800, 0, 0,  1,  64, 640,  64, 640, 0, 1, 0, 2);
        add(16'h0000, 0, 0, 31, 128, 640, 128, 640, 0, 0, 0, 2);
        add(16'h0000, 0, 0, 14, 128, 395, 128, 395, 0, 0, 0, 2);
        add(16'h0000, 3, 0,  1, 125, 385, 131, 387, 1, 0, 1, 2);
        add(16'h0000, 2, 0, 31,  32, 571, 224, 635, 1, 0, 1, 2);
        add(16'h0000, 0, 0,  1,  29, 593, 224, 635, 1, 0, 1, 2);
        add(16'h0000, 0, 0,  2,  23, 640, 224, 635, 1, 0, 1, 2);
        add(16'h0000, 0, 0,  1,  23, 640, 224, 635, 0, 1, 1, 2);
        add(16'h0000, 2, 0, 31, 128, 640, 128, 640, 0, 0, 1, 2);
        add(16'h0000, 0, 0,  1, 128, 616, 128, 616, 0, 0, 1, 2);
        add(16'h0000, 0, 1,  1, 128, 593, 128, 593, 0, 0, 1, 2);
        add(16'h0000, 0, 0,  1, 125, 571, 131, 573, 1, 0, 2, 2);

        // Reset state, held through several cycles.
        repeat (3) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        e = '{448, 640, 448, 640, 0, 1, 0, 0};
        sb.push_back(e);
        compare_pop("reset");

        for (int i = 0; i < vq.size(); i++) begin
            random_in = vq[i].rnd;
            for (int p = 0; p < vq[i].npulse; p++) begin
                @(negedge clk_in);
                split_in = 1'b1;
                @(negedge clk_in);
                split_in = 1'b0;
            end
            for (int k = 0; k < vq[i].n; k++) begin
                tick(vq[i].sim && (k == 0), k == vq[i].n - 1, vq[i].e, $sformatf("v%0d", i));
            end
        end

        // Reset coincident with a tick while split: reset wins, counter restarts.
        random_in = 16'h0000;
        @(negedge clk_in);
        rst_in        = 1'b1;
        frame_done_in = 1'b1;
        split_in      = 1'b1;
        e = '{448, 640, 448, 640, 0, 1, 0, 0};
        sb.push_back(e);
        @(posedge clk_in);
        #1;
        rst_in        = 1'b0;
        frame_done_in = 1'b0;
        split_in      = 1'b0;
        compare_pop("midreset");
        e = '{448, 640, 448, 640, 0, 1, 0, 0};
        for (int k = 0; k < 30; k++) tick(1'b0, k == 29, e, "restart30");
        e = '{128, 640, 128, 640, 0, 0, 0, 0};
        tick(1'b0, 1'b1, e, "restart31");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
